// File: rtl/grid_router_gcr_rx_if.sv
// Link bundle between the serial GCR line / router input stage and the receive decoder.
// The master side drives the line strobe and the error-clear request; the slave is the decoder.
interface grid_router_gcr_rx_if;
   logic       bit_en;
   logic       din;
   logic       clr_err;
   logic       o_valid;
   logic [5:0] o_data;
   logic       o_sof;
   logic       o_cerr;
   logic       o_eof;
   logic       o_ferr;
   logic       o_active;
   logic [7:0] err_cnt;

   modport master (
      output bit_en, din, clr_err,
      input  o_valid, o_data, o_sof, o_cerr, o_eof, o_ferr, o_active, err_cnt
   );

   modport slave (
      input  bit_en, din, clr_err,
      output o_valid, o_data, o_sof, o_cerr, o_eof, o_ferr, o_active, err_cnt
   );
endinterface

// File: rtl/grid_router_gcr_rx.sv
// Serial GCR receive decoder: aligns on the idle zero run, deserialises 8-bit symbols MSB first
// and decodes them to 6-bit values with code/framing error flags and a saturating error count.
module grid_router_gcr_rx #(
   parameter int ZRUN = 3
) (
   input logic clk,
   input logic rst,
   grid_router_gcr_rx_if.slave link
);

   localparam logic [1:0] ST_HUNT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [2:0] ZMAX  = 3'(ZRUN);
   localparam logic [3:0] ZMAX4 = 4'(ZRUN);

   localparam logic [7:0] CODES [64] = '{
      8'h96, 8'h97, 8'h9A, 8'h9B, 8'h9D, 8'h9E, 8'h9F, 8'hA6,
      8'hA7, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB2, 8'hB3,
      8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB9, 8'hBA, 8'hBB, 8'hBC,
      8'hBD, 8'hBE, 8'hBF, 8'hCB, 8'hCD, 8'hCE, 8'hCF, 8'hD3,
      8'hD6, 8'hD7, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE,
      8'hDF, 8'hE5, 8'hE6, 8'hE7, 8'hE9, 8'hEA, 8'hEB, 8'hEC,
      8'hED, 8'hEE, 8'hEF, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6,
      8'hF7, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF
   };

   logic [1:0] state;
   logic [2:0] zcnt;
   logic [3:0] bcnt;
   logic [7:0] shreg;
   logic       sof_pending;

   logic       o_valid_q;
   logic [5:0] o_data_q;
   logic       o_sof_q;
   logic       o_cerr_q;
   logic       o_eof_q;
   logic       o_ferr_q;
   logic [7:0] err_cnt_q;

   logic [2:0] zcnt_next;
   logic       zrun_hit;
   logic [7:0] sym_next;
   logic [3:0] bcnt_inc;
   logic       sym_done;
   logic       partial_ferr;
   logic       dec_legal;
   logic [5:0] dec_val;
   logic       err_event;

   always_comb begin
      zcnt_next = 3'd0;
      if (!link.din) begin
         zcnt_next = (zcnt == ZMAX) ? zcnt : zcnt + 3'd1;
      end
   end

   assign zrun_hit     = (zcnt_next == ZMAX);
   assign sym_next     = {shreg[6:0], link.din};
   assign bcnt_inc     = bcnt + 4'd1;
   assign sym_done     = (bcnt_inc == 4'd8);
   // Any bit count beyond the zero run itself means a 1 was part of the unfinished symbol.
   assign partial_ferr = (bcnt_inc > ZMAX4);

   always_comb begin
      dec_legal = 1'b0;
      dec_val   = 6'd0;
      for (int i = 0; i < 64; i++) begin
         if (sym_next == CODES[i]) begin
            dec_legal = 1'b1;
            dec_val   = 6'(i);
         end
      end
   end

   assign err_event = link.bit_en && (state == ST_DATA) &&
                      (zrun_hit ? partial_ferr : (sym_done && !dec_legal));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_HUNT;
         zcnt        <= 3'd0;
         bcnt        <= 4'd0;
         shreg       <= 8'd0;
         sof_pending <= 1'b0;
         o_valid_q   <= 1'b0;
         o_data_q    <= 6'd0;
         o_sof_q     <= 1'b0;
         o_cerr_q    <= 1'b0;
         o_eof_q     <= 1'b0;
         o_ferr_q    <= 1'b0;
      end else begin
         o_valid_q <= 1'b0;
         o_data_q  <= 6'd0;
         o_sof_q   <= 1'b0;
         o_cerr_q  <= 1'b0;
         o_eof_q   <= 1'b0;
         o_ferr_q  <= 1'b0;
         if (link.bit_en) begin
            zcnt  <= zcnt_next;
            shreg <= sym_next;
            case (state)
               ST_HUNT: begin
                  if (zrun_hit) begin
                     state <= ST_IDLE;
                  end
               end
               ST_IDLE: begin
                  if (link.din) begin
                     bcnt        <= 4'd1;
                     sof_pending <= 1'b1;
                     state       <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  // End of frame wins over symbol completion so valid and eof never coincide.
                  if (zrun_hit) begin
                     o_eof_q  <= 1'b1;
                     o_ferr_q <= partial_ferr;
                     bcnt     <= 4'd0;
                     state    <= ST_IDLE;
                  end else if (sym_done) begin
                     o_valid_q   <= 1'b1;
                     o_sof_q     <= sof_pending;
                     o_cerr_q    <= !dec_legal;
                     o_data_q    <= dec_legal ? dec_val : 6'd0;
                     sof_pending <= 1'b0;
                     bcnt        <= 4'd0;
                  end else begin
                     bcnt <= bcnt_inc;
                  end
               end
               default: begin
                  state <= ST_HUNT;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= 8'd0;
      end else if (link.clr_err) begin
         err_cnt_q <= 8'd0;
      end else if (err_event && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign link.o_valid  = o_valid_q;
   assign link.o_data   = o_data_q;
   assign link.o_sof    = o_sof_q;
   assign link.o_cerr   = o_cerr_q;
   assign link.o_eof    = o_eof_q;
   assign link.o_ferr   = o_ferr_q;
   assign link.o_active = (state == ST_DATA);
   assign link.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_grid_router_gcr_rx.sv
// Self-checking bench for grid_router_gcr_rx: frames are built from the GCR code table,
// expected output events are queued as frames are sent and matched by a negedge monitor.
module tb_grid_router_gcr_rx;

   localparam int ZRUN = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   grid_router_gcr_rx_if link();

   grid_router_gcr_rx #(.ZRUN(ZRUN)) dut (
      .clk  (clk),
      .rst  (rst),
      .link (link)
   );

   int compared   = 0;
   int mismatched = 0;

   // Event word: {eof, valid, sof, cerr, ferr, data[5:0]}
   logic [10:0] expQ[$];
   int          errModel = 0;
   bit          sofNext  = 1'b0;
   int          gapMax   = 0;
   int          decodeMap[int];

   logic [7:0] codeTab [64] = '{
      8'h96, 8'h97, 8'h9A, 8'h9B, 8'h9D, 8'h9E, 8'h9F, 8'hA6,
      8'hA7, 8'hAB, 8'hAC, 8'hAD, 8'hAE, 8'hAF, 8'hB2, 8'hB3,
      8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB9, 8'hBA, 8'hBB, 8'hBC,
      8'hBD, 8'hBE, 8'hBF, 8'hCB, 8'hCD, 8'hCE, 8'hCF, 8'hD3,
      8'hD6, 8'hD7, 8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE,
      8'hDF, 8'hE5, 8'hE6, 8'hE7, 8'hE9, 8'hEA, 8'hEB, 8'hEC,
      8'hED, 8'hEE, 8'hEF, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6,
      8'hF7, 8'hF9, 8'hFA, 8'hFB, 8'hFC, 8'hFD, 8'hFE, 8'hFF
   };

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] lookup(input logic [7:0] c);
      if (decodeMap.exists(int'(c))) return {1'b1, 6'(decodeMap[int'(c)])};
      return 7'd0;
   endfunction

   function automatic bit has3Zeros(input logic [7:0] c);
      for (int i = 0; i <= 5; i++) begin
         if (c[i +: 3] == 3'b000) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Illegal symbol framed by 1s so it can never form a zero run with its neighbours.
   function automatic logic [7:0] randomIllegal();
      logic [7:0] c;
      do begin
         c = {1'b1, 6'($urandom), 1'b1};
      end while (decodeMap.exists(int'(c)) || has3Zeros(c));
      return c;
   endfunction

   task automatic applyStimulus(input logic b, input logic clr);
      int gap;
      link.bit_en  = 1'b1;
      link.din     = b;
      link.clr_err = clr;
      @(posedge clk);
      #1;
      link.bit_en  = 1'b0;
      link.din     = 1'b0;
      link.clr_err = 1'b0;
      gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendZeros(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic startFrame();
      sendZeros(ZRUN);
      sofNext = 1'b1;
   endtask

   task automatic sendSym(input logic [7:0] code, input logic [6:0] exp, input logic clr);
      expQ.push_back({1'b0, 1'b1, sofNext, ~exp[6], 1'b0, exp[5:0]});
      sofNext = 1'b0;
      if (clr) errModel = 0;
      else if (!exp[6] && errModel < 255) errModel++;
      for (int i = 7; i >= 0; i--) begin
         applyStimulus(code[i], clr && (i == 0));
      end
   endtask

   task automatic endFrame();
      expQ.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});
      sendZeros(ZRUN);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (link.o_valid && link.o_eof) checkOutput("valid_eof_overlap", 1, 0);
         if (!link.o_valid && (link.o_sof || link.o_cerr))
            checkOutput("qual_without_valid", {link.o_sof, link.o_cerr}, 0);
         if (!link.o_eof && link.o_ferr) checkOutput("ferr_without_eof", 1, 0);
         if (link.o_valid || link.o_eof) begin
            logic [10:0] got;
            got = {link.o_eof, link.o_valid, link.o_sof, link.o_cerr, link.o_ferr, link.o_data};
            if (expQ.size() == 0) checkOutput("unexpected_event", 32'(got), 0);
            else checkOutput("event", 32'(got), 32'(expQ.pop_front()));
         end
      end
   end

   initial begin
      link.bit_en  = 1'b0;
      link.din     = 1'b0;
      link.clr_err = 1'b0;
      for (int i = 0; i < 64; i++) decodeMap[int'(codeTab[i])] = i;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs", {link.o_valid, link.o_sof, link.o_cerr, link.o_eof,
                                    link.o_ferr, link.o_active, link.o_data}, 0);
      checkOutput("reset_err_cnt", link.err_cnt, 0);
      rst = 1'b0;

      // Basic frame
      startFrame();
      sendSym(8'h96, {1'b1, 6'h00}, 1'b0);
      checkOutput("active_in_frame", link.o_active, 1);
      sendSym(8'hFF, {1'b1, 6'h3F}, 1'b0);
      sendSym(8'hBA, {1'b1, 6'h15}, 1'b0);
      endFrame();
      checkOutput("active_after_eof", link.o_active, 0);
      checkOutput("err_cnt_clean", link.err_cnt, 0);

      // Illegal symbol mid-frame
      startFrame();
      sendSym(8'h97, {1'b1, 6'h01}, 1'b0);
      sendSym(8'hC9, 7'd0, 1'b0);
      sendSym(8'hD3, {1'b1, 6'h1F}, 1'b0);
      endFrame();
      checkOutput("err_cnt_cerr", link.err_cnt, 32'(errModel));

      // Frame cut short mid-symbol
      sendZeros(ZRUN);
      expQ.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0});
      errModel++;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      sendZeros(3);
      checkOutput("err_cnt_ferr", link.err_cnt, 32'(errModel));
      startFrame();
      sendSym(8'hE5, {1'b1, 6'h29}, 1'b0);
      endFrame();

      // All 64 codes with sparse random strobes, then continuous strobes
      gapMax = 8;
      startFrame();
      for (int i = 0; i < 64; i++) sendSym(codeTab[i], {1'b1, 6'(i)}, 1'b0);
      endFrame();
      gapMax = 0;
      startFrame();
      for (int i = 0; i < 64; i++) sendSym(codeTab[i], lookup(codeTab[i]), 1'b0);
      endFrame();
      checkOutput("err_cnt_all_codes", link.err_cnt, 32'(errModel));

      // Reset in the middle of a frame
      startFrame();
      sendSym(8'h96, {1'b1, 6'h00}, 1'b0);
      repeat (4) applyStimulus(1'b1, 1'b0);
      rst = 1'b1;
      #2;
      checkOutput("midframe_reset_outputs", {link.o_valid, link.o_sof, link.o_cerr, link.o_eof,
                                             link.o_ferr, link.o_active, link.o_data}, 0);
      checkOutput("midframe_reset_err_cnt", link.err_cnt, 0);
      checkOutput("midframe_reset_pending", expQ.size(), 0);
      errModel = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("unframed_not_active", link.o_active, 0);
      startFrame();
      sendSym(8'hE5, {1'b1, 6'h29}, 1'b0);
      endFrame();

      // Error counter saturation and clear priority
      gapMax = 1;
      startFrame();
      for (int i = 0; i < 260; i++) sendSym(randomIllegal(), 7'd0, 1'b0);
      checkOutput("err_cnt_saturated", link.err_cnt, 32'(errModel));
      checkOutput("err_cnt_is_255", link.err_cnt, 255);
      sendSym(randomIllegal(), 7'd0, 1'b1);
      checkOutput("err_cnt_clear_priority", link.err_cnt, 32'(errModel));
      sendSym(8'hE5, {1'b1, 6'h29}, 1'b0);
      endFrame();
      checkOutput("err_cnt_after_clear", link.err_cnt, 0);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("events_pending", expQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/grid_router_gcr_rx.md
# grid_router_gcr_rx

Serial GCR receive decoder for the grid router links, the receive end of the 6-bit to 8-bit GCR symbol path. It takes a strobed serial bit stream, finds frame and symbol alignment from the line's idle run of zeros, and deserialises 8-bit GCR symbols MSB first. Each symbol is decoded back to its 6-bit value and presented to the router input stage as a registered, single-cycle-valid word. It also flags code and framing errors and keeps a saturating error count.

## Interface
- ZRUN, 3: consecutive zeros that mark idle or end of frame; legal values 3..7.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- bit_en  in  1  line bit strobe; `din` is sampled only when high.
- din  in  1  serial line bit, MSB of each symbol first.
- clr_err  in  1  synchronous clear of `err_cnt`.
- o_valid  out  1  one-clk pulse: `o_data`, `o_sof` and `o_cerr` are valid.
- o_data  out  6  decoded value; 0 when `o_cerr` is set.
- o_sof  out  1  qualifies `o_valid`: first symbol of a frame.
- o_cerr  out  1  qualifies `o_valid`: the 8-bit symbol is not a legal code.
- o_eof  out  1  one-clk pulse: frame ended.
- o_ferr  out  1  qualifies `o_eof`: frame ended mid-symbol.
- o_active  out  1  high while in a frame.
- err_cnt  out  8  saturating count of code and framing errors.

## Operation
- Code set, for values 0x00..0x3F in order: 96 97 9A 9B 9D 9E 9F A6 A7 AB AC AD AE AF B2 B3 B4 B5 B6 B7 B9 BA BB BC BD BE BF CB CD CE CF D3 D6 D7 D9 DA DB DC DD DE DF E5 E6 E7 E9 EA EB EC ED EE EF F2 F3 F4 F5 F6 F7 F9 FA FB FC FD FE FF.
- Code properties:
  - Every code has MSB 1.
  - No code, and no concatenation of codes, contains 3 consecutive zeros.
  - A run of ZRUN zeros therefore only occurs on an idle line.
- Zero-run counter `zcnt`:
  - Increments on each `bit_en` with `din`=0, saturating at ZRUN.
  - Clears on each `bit_en` with `din`=1.
- State machine (all state changes occur only on `bit_en` cycles):
  - HUNT (reset state): wait until `zcnt` reaches ZRUN, then go to IDLE.
  - IDLE: the first 1 is the MSB of symbol 0. Load the shift register, set bit count to 1, set sof_pending, go to DATA.
  - DATA: shift in bits. When the 8th bit arrives:
    - Decode the 8-bit symbol and pulse `o_valid`.
    - `o_sof` = sof_pending; then clear sof_pending.
    - Reset bit count to 0 and stay in DATA.
  - DATA, when `zcnt` reaches ZRUN:
    - Pulse `o_eof` and go to IDLE.
    - `o_ferr` = 1 if the partial symbol contains any 1 (bit count > ZRUN); otherwise a clean end.
- `o_active` = (state == DATA).
- Illegal symbol: `o_valid`=1, `o_cerr`=1, `o_data`=0; stay in DATA.
- `err_cnt`:
  - +1 on each `o_cerr` pulse and each `o_eof` with `o_ferr` set; saturates at 255.
  - `clr_err` clears it and has priority over an increment in the same cycle.
- No backpressure: symbols arrive at least 8 `bit_en` apart, so no buffering is needed.

## Timing
- Reset values:
  - `o_valid`, `o_sof`, `o_cerr`, `o_eof`, `o_ferr`, `o_active` = 0.
  - `o_data` = 0, `err_cnt` = 0.
  - State HUNT, `zcnt` = 0, bit count = 0.
- Latency: outputs are registered and update on the clk edge that samples the `bit_en` cycle delivering the 8th symbol bit or the ZRUN-th zero.
- `o_valid` and `o_eof` are high for exactly one clk, regardless of the `bit_en` rate (`bit_en` may be continuously high).
- `o_valid` and `o_eof` are never high in the same cycle.
- The qualifier outputs are 0 whenever their strobe is low.
- `rst` asserted mid-frame: all outputs clear immediately with no `o_eof`. After release, ZRUN zeros are required before a new frame is recognised.
- With `bit_en` low, nothing changes except `clr_err`.

## Test plan
- Reset release, then 3 zeros, then 0x96, 0xFF, 0xBA, then 3 zeros -> three `o_valid` pulses with `o_data` 0x00, 0x3F, 0x15; `o_sof` only on the first; then `o_eof` with `o_ferr`=0; `err_cnt`=0.
- Frame containing 0xC9 (illegal) between 0x97 and 0xD3 -> data 0x01, then `o_cerr`=1 with data 0, then 0x1F; `err_cnt`=1.
- After 3 idle zeros, bits 1,0,1,1,0,0,0 -> `o_eof` with `o_ferr`=1 and no `o_valid`; `err_cnt`+1; the next frame decodes normally.
- `bit_en` at 1-in-5 clks with random gaps, and also continuously high, sending all 64 codes -> values 0x00..0x3F in order, each `o_valid` exactly one clk wide.
- Pulse `rst` after 12 bits of a frame -> outputs 0 and no `o_eof`; a leading 1 without a preceding 3-zero run is ignored; the following framed 0xE5 decodes to 0x29.
- Inject 260 illegal symbols -> `err_cnt` holds at 255; `clr_err` together with an error -> 0.
